button_press_generator: RTL and testbench
=========================================

Name: button_press_generator

Overview:
Transmitter counterpart to the team's debounced button-counter receiver. It accepts a press count through a valid/ready handshake and emits exactly that many active-low press pulses on press_n, with programmable hold and gap times. press_n connects directly to a counter's active-low increment-button input. The block is used for board self-test and simulation stimulus, and sits between a control FSM or host register and the counter under test.

Parameters:
HOLD_CYCLES, 1200000, clk cycles press_n is held low per press (100 ms at 12 MHz); must be >= 1
GAP_CYCLES, 1200000, clk cycles press_n is held high after each press; must be >= 1
COUNT_W, 4, width of req_count and presses_sent
BOUNCE_PERIOD, 1000, clk cycles per bounce segment; used only with BOUNCE_EN
BOUNCE_TOGGLES, 4, number of low/high bounce pairs; used only with BOUNCE_EN

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
req_valid  input  1  request strobe
req_count  input  COUNT_W  number of presses to emit; sampled on accept
req_ready  output  1  high only in IDLE
press_n  output  1  generated button line; active-low; idle high
busy  output  1  high in every state except IDLE
done  output  1  single-cycle pulse when a request completes
presses_sent  output  COUNT_W  presses completed for the current or last request

Behaviour:
- Reset (async, immediate): state IDLE, press_n=1, req_ready=1, busy=0, done=0, presses_sent=0, internal counters=0. Reset during PRESS releases the line at once; the request is discarded.
- All outputs are registered, except req_ready and busy, which decode the state register directly.
- Accept: on a rising edge with req_valid=1 in IDLE, latch req_count into remaining and clear presses_sent to 0. req_valid outside IDLE is ignored and never queued.
- FSM states: IDLE, PRESS, RELEASE, DONE.
- IDLE -> PRESS on accept with req_count != 0. IDLE -> DONE on accept with req_count == 0, so no press is emitted.
- PRESS: press_n=0 for exactly HOLD_CYCLES cycles, beginning the cycle after accept. On the last hold cycle: presses_sent+1, remaining-1, then go to RELEASE.
- RELEASE: press_n=1 for exactly GAP_CYCLES cycles. Then go to PRESS if remaining != 0, else DONE.
- DONE: done=1 for one cycle, then IDLE. req_ready reasserts the cycle after done.
- Timing: accept at edge k with count N>0 gives done high during cycle k + N*(HOLD_CYCLES+GAP_CYCLES) + 1.
- Timer: a single down-counter sized by $clog2 of max(HOLD_CYCLES, GAP_CYCLES). It reloads on each state entry and never wraps.
- Max count is 2^COUNT_W-1; presses_sent never wraps within a request.
- presses_sent holds its value after done until the next accept.

Optional Feature:
BUTTON_PRESS_GENERATOR_BOUNCE_EN
- Defined: the first 2*BOUNCE_TOGGLES*BOUNCE_PERIOD cycles of each PRESS window are bounce. press_n alternates 0/1 every BOUNCE_PERIOD cycles, starting at 0. It then stays 0 for the rest of the window.
- Total PRESS length stays HOLD_CYCLES, and the counting rules are unchanged.
- Elaboration error if HOLD_CYCLES <= 2*BOUNCE_TOGGLES*BOUNCE_PERIOD.
- Undefined: press_n is a clean low for the whole window, and the bounce parameters are unused.

Test Plan:
- HOLD=4, GAP=3; accept count=3 at edge k -> press_n low k+1..k+4, k+8..k+11, k+15..k+18, high otherwise; done only at k+22; presses_sent=3; req_ready=1 at k+23.
- Accept count=0 -> press_n stays 1; done pulses at k+1; presses_sent=0; req_ready back at k+2.
- req_valid held high with count=5 during a count=2 transfer -> exactly 2 presses emitted; second request not taken until IDLE.
- Assert rst mid-PRESS of press 2 -> press_n=1 and presses_sent=0 the same cycle; no done; req_ready=1 after rst drops.
- Loopback into the team's button counter with HOLD/GAP above its debounce window; count=15 -> counter LEDs read 4'hF.
- BOUNCE_EN, HOLD=40, BOUNCE_PERIOD=2, BOUNCE_TOGGLES=4 -> 8 alternating 2-cycle segments then 24 cycles low; counter under test still increments exactly once per press.

Source files
------------

// File: rtl/button_press_generator.sv
// button_press_generator
//   Emits a requested number of active-low press pulses on press_n. Each
//   press holds the line low for HOLD_CYCLES, followed by a high gap of
//   GAP_CYCLES. A request is a press count taken through a valid/ready
//   handshake. done pulses for one cycle when the last gap has finished.
//
//   Optional feature macro: BUTTON_PRESS_GENERATOR_BOUNCE_EN
//     When defined, each press window starts with BOUNCE_TOGGLES low/high
//     pairs of BOUNCE_PERIOD cycles each. After that the line stays low for
//     the rest of the window.
//
// Ports
//   clk          : system clock
//   rst          : asynchronous, active-high reset
//   req_valid    : request strobe, taken only while idle
//   req_count    : number of presses, sampled on accept
//   req_ready    : high only while idle (decoded from state)
//   press_n      : generated button line, active-low, idle high (registered)
//   busy         : high in every state except idle (decoded from state)
//   done         : one-cycle completion pulse (registered)
//   presses_sent : presses completed for the current or last request (registered)
module button_press_generator #(
  parameter int unsigned HOLD_CYCLES    = 1200000,
  parameter int unsigned GAP_CYCLES     = 1200000,
  parameter int unsigned COUNT_W        = 4,
  parameter int unsigned BOUNCE_PERIOD  = 1000,
  parameter int unsigned BOUNCE_TOGGLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic [COUNT_W-1:0] req_count,
  output logic               req_ready,
  output logic               press_n,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] presses_sent
);

  localparam int unsigned MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned TIMER_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  // Parameter sanity checks at elaboration time
  if (HOLD_CYCLES < 1) begin : g_chk_hold
    $error("button_press_generator: HOLD_CYCLES must be >= 1");
  end
  if (GAP_CYCLES < 1) begin : g_chk_gap
    $error("button_press_generator: GAP_CYCLES must be >= 1");
  end
  if (BOUNCE_PERIOD == 0 && BOUNCE_TOGGLES != 0) begin : g_chk_bperiod
    $error("button_press_generator: BOUNCE_PERIOD must be nonzero when BOUNCE_TOGGLES is nonzero");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESS   = 2'd1,
    ST_RELEASE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [COUNT_W-1:0]   remaining_q, remaining_d;
  logic [COUNT_W-1:0]   sent_q, sent_d;
  logic                 press_n_q, press_n_d;
  logic                 done_q, done_d;

`ifdef BUTTON_PRESS_GENERATOR_BOUNCE_EN
  localparam int unsigned BNC_SEGS = 2 * BOUNCE_TOGGLES;
  localparam int unsigned SEG_W    = (BNC_SEGS > 0) ? $clog2(BNC_SEGS + 1) : 1;
  localparam int unsigned BT_W     = (BOUNCE_PERIOD > 1) ? $clog2(BOUNCE_PERIOD) : 1;

  if (HOLD_CYCLES <= BNC_SEGS * BOUNCE_PERIOD) begin : g_chk_bounce
    $error("button_press_generator: HOLD_CYCLES must exceed 2*BOUNCE_TOGGLES*BOUNCE_PERIOD");
  end

  // seg: bounce segments still to start (0 = bounce over); bt: cycles left in segment
  logic [SEG_W-1:0] seg_q, seg_d;
  logic [BT_W-1:0]  bt_q, bt_d;
`endif

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      remaining_q <= '0;
      sent_q      <= '0;
      press_n_q   <= 1'b1;
      done_q      <= 1'b0;
`ifdef BUTTON_PRESS_GENERATOR_BOUNCE_EN
      seg_q       <= '0;
      bt_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      remaining_q <= remaining_d;
      sent_q      <= sent_d;
      press_n_q   <= press_n_d;
      done_q      <= done_d;
`ifdef BUTTON_PRESS_GENERATOR_BOUNCE_EN
      seg_q       <= seg_d;
      bt_q        <= bt_d;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    remaining_d = remaining_q;
    sent_d      = sent_q;
    press_n_d   = 1'b1;
    done_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          remaining_d = req_count;
          sent_d      = '0;
          if (req_count != '0) begin
            state_d = ST_PRESS;
            timer_d = TIMER_W'(HOLD_CYCLES - 1);
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_PRESS: begin
        // Timer at zero marks the last hold cycle of this press
        if (timer_q == '0) begin
          sent_d      = sent_q + COUNT_W'(1);
          remaining_d = remaining_q - COUNT_W'(1);
          state_d     = ST_RELEASE;
          timer_d     = TIMER_W'(GAP_CYCLES - 1);
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      ST_RELEASE: begin
        if (timer_q == '0) begin
          if (remaining_q != '0) begin
            state_d = ST_PRESS;
            timer_d = TIMER_W'(HOLD_CYCLES - 1);
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it
    done_d = (state_d == ST_DONE);

`ifdef BUTTON_PRESS_GENERATOR_BOUNCE_EN
    seg_d = seg_q;
    bt_d  = bt_q;
    if (state_d == ST_PRESS && state_q != ST_PRESS) begin
      seg_d = SEG_W'(BNC_SEGS);
      bt_d  = BT_W'(BOUNCE_PERIOD - 1);
    end else if (state_q == ST_PRESS && seg_q != '0) begin
      if (bt_q == '0) begin
        seg_d = seg_q - SEG_W'(1);
        bt_d  = BT_W'(BOUNCE_PERIOD - 1);
      end else begin
        bt_d = bt_q - BT_W'(1);
      end
    end
    // Segment parity equals seg parity (BNC_SEGS is even): even = low, odd = high
    press_n_d = (state_d == ST_PRESS) ? seg_d[0] : 1'b1;
`else
    press_n_d = (state_d != ST_PRESS);
`endif
  end

  assign req_ready    = (state_q == ST_IDLE);
  assign busy         = (state_q != ST_IDLE);
  assign press_n      = press_n_q;
  assign done         = done_q;
  assign presses_sent = sent_q;

endmodule

// File: tb/tb_button_press_generator.sv
// Testbench for button_press_generator (default build, HOLD=4, GAP=3, COUNT_W=4).
// The expected waveform for each request is computed from the press schedule.
// Cycle j after the accept edge has a fixed meaning: press p covers cycles
// p*(H+G)+1 .. p*(H+G)+H. done falls in cycle N*(H+G)+1, or in cycle 1 when N is 0.
module tb_button_press_generator;

  localparam int unsigned H  = 4;
  localparam int unsigned G  = 3;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic [CW-1:0] req_count;
  logic          req_ready;
  logic          press_n;
  logic          busy;
  logic          done;
  logic [CW-1:0] presses_sent;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  button_press_generator #(
    .HOLD_CYCLES (H),
    .GAP_CYCLES  (G),
    .COUNT_W     (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_count    (req_count),
    .req_ready    (req_ready),
    .press_n      (press_n),
    .busy         (busy),
    .done         (done),
    .presses_sent (presses_sent)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic exp_pn, input logic exp_done,
                               input int unsigned exp_sent, input logic exp_ready);
    check({tag, ".press_n"},      32'(press_n),      32'(exp_pn));
    check({tag, ".done"},         32'(done),         32'(exp_done));
    check({tag, ".presses_sent"}, 32'(presses_sent), exp_sent);
    check({tag, ".req_ready"},    32'(req_ready),    32'(exp_ready));
    check({tag, ".busy"},         32'(busy),         32'(!exp_ready));
  endtask

  // Idle cycles: line high, no done, presses_sent holds its last value
  task automatic idle_check(input int unsigned cycles, input int unsigned sent);
    for (int unsigned i = 0; i < cycles; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      check_outputs("idle", 1'b1, 1'b0, sent, 1'b1);
    end
  endtask

  // mode 0: req_valid low while busy; 1: random noise on req_valid/req_count;
  // 2: req_valid held high with count 5 throughout, still high when idle returns.
  // pre: req_valid/req_count were already driven for this accept.
  task automatic run_req(input int unsigned n, input int mode, input bit pre);
    int unsigned per;
    int unsigned last;
    logic        exp_pn;
    int unsigned exp_sent;
    per  = H + G;
    last = (n == 0) ? 1 : n * per + 1;
    if (!pre) begin
      @(negedge clk);
      req_valid = 1'b1;
      req_count = CW'(n);
    end
    @(posedge clk);
    for (int unsigned j = 1; j <= last + 1; j++) begin
      @(negedge clk);
      exp_pn = !(n != 0 && j <= n * per && ((j - 1) % per) < H);
      exp_sent = 0;
      for (int unsigned p = 0; p < n; p++)
        if (p * per + H < j) exp_sent++;
      check_outputs($sformatf("req%0d.j%0d", n, j), exp_pn, (j == last), exp_sent, (j == last + 1));
      if (j == last + 1) begin
        req_valid = (mode == 2);
        req_count = CW'(5);
      end else begin
        case (mode)
          1: begin
            req_valid = 1'($urandom_range(0, 1));
            req_count = CW'($urandom);
          end
          2: begin
            req_valid = 1'b1;
            req_count = CW'(5);
          end
          default: req_valid = 1'b0;
        endcase
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_count = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check_outputs("reset", 1'b1, 1'b0, 0, 1'b1);
    rst = 1'b0;
    idle_check(2, 0);

    // Directed: count 3, then count 0
    run_req(3, 0, 1'b0);
    idle_check(3, 3);
    run_req(0, 0, 1'b0);
    idle_check(2, 0);

    // req_valid held high with count 5 during a count-2 transfer; the second
    // request is taken exactly when idle returns
    run_req(2, 2, 1'b0);
    run_req(5, 0, 1'b1);
    idle_check(2, 5);

    // Max count
    run_req(15, 0, 1'b0);
    idle_check(2, 15);

    // Reset in the middle of press 2 of a count-3 request
    @(negedge clk);
    req_valid = 1'b1;
    req_count = CW'(3);
    @(posedge clk);
    for (int unsigned j = 1; j <= 9; j++) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
    check("mid_press.press_n_before", 32'(press_n), 32'd0);
    check("mid_press.sent_before", 32'(presses_sent), 32'd1);
    rst = 1'b1;
    #1;
    check_outputs("rst_async", 1'b1, 1'b0, 0, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle_check(12, 0);

    // Randomized requests with random noise and idle gaps
    for (int i = 0; i < 10; i++) begin
      int unsigned n;
      n = $urandom_range(0, 15);
      run_req(n, int'($urandom_range(0, 1)), 1'b0);
      idle_check($urandom_range(0, 3), n);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
